mcm_scheduler: RTL and testbench
================================

# mcm_scheduler

Sequencer for the matrix-chain-multiplication dynamic program. It walks chain length L, start index i and split point k, and drives the three-input multiply/add/min computation unit with dimension and cost-table operands. After each sub-chain it writes the winning cost and split index back into external cost and split tables. It sits between the host (dimension load, start/done) and the computation unit plus table RAMs.

## Interface
Parameters:
- N, 8: maximum number of matrices supported.
- PW, 8: dimension width.
- CW, 32: cost and k width.
- IW, $clog2(N+1): index width. Table address is {i,j}, 2*IW bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- dim_we  in  1  write dimension p[dim_addr]; ignored while busy.
- dim_addr  in  IW  dimension index, 0..N.
- dim_data  in  PW  dimension value.
- start  in  1  begin run; sampled only in IDLE.
- n  in  IW  number of matrices, sampled with start.
- busy  out  1  high from the cycle after accepted start through DONE.
- done  out  1  one-cycle pulse at end of run.
- err  out  1  valid with done; 1 when n==0 or n>N.
- cu_clr  out  1  clear accumulator (min := all-ones, k := 0).
- cu_en  out  1  accumulator compares and updates this cycle.
- pi, pk, pj  out  PW each  p[i-1], p[k], p[j].
- kc  out  CW  current k, zero-extended.
- tbl_ra0, tbl_ra1  out  2*IW each  cost-table read addresses {i,k} and {k+1,j}.
- mki, mkj1  in  CW each  asynchronous read data for ra0 and ra1.
- cu_min, cu_ko  in  CW each  accumulator registered min and argmin.
- tbl_we  out  1  write cost and split tables.
- tbl_wa  out  2*IW  write address {i,j}.
- cost_wd, split_wd  out  CW each  write data.

## Operation
- States: IDLE, INIT, SETUP, ITER, WB, DONE.
- IDLE to INIT on start when 1≤n≤N. For an invalid n, go straight to DONE with err=1 and perform no table writes.
- INIT: i = 1..n, one cycle each. tbl_we=1, tbl_wa={i,i}, cost_wd=0, split_wd=0. Then set L=2, i=1 and go to SETUP. If n==1, go to DONE instead.
- SETUP: j = i+L-1, k = i. cu_clr=1 for one cycle.
- ITER: cu_en=1 and operands drive (i,j,k). Increment k each cycle. Leave after the k==j-1 cycle.
- WB: tbl_we=1, tbl_wa={i,j}, cost_wd=cu_min, split_wd=cu_ko.
  - If i < n-L+1: i++ and go to SETUP.
  - Else if L < n: L++, i=1 and go to SETUP.
  - Else go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Min tie rule: the accumulator uses strict less-than, so the lowest k wins on equal cost.
- Arithmetic overflow wraps in the computation unit. The scheduler does not detect it.
- start while busy is ignored. dim_we while busy is ignored; the dimension file is stable for the whole run.
- Operand outputs hold their last values outside ITER. cu_en=0 guarantees no accumulator update.

## Timing
- Reset values: busy, done, err, cu_clr, cu_en, tbl_we = 0. All address, operand and write-data outputs = 0. State = IDLE. The dimension file resets to 0.
- Reset asserted mid-run returns to IDLE immediately. Table contents are left partial and undefined.
- Start accepted at cycle 0. INIT occupies cycles 1..n.
- Each (i,j) pair costs L+1 cycles: SETUP 1, ITER L-1, WB 1.
- Total to done = 1 + n + Σ_{L=2..n}(n-L+1)(L+1). For n=3, done is in cycle 14.
- mki and mkj1 are consumed combinationally in the same ITER cycle they are addressed. The table RAM must have asynchronous read.
- cu_min and cu_ko read in WB reflect the final ITER edge.
- Invalid n: done and err in cycle 1. busy stays 0.

## Structure
- Package mcm_pkg holds N, PW, CW, IW, the state enum, and an address-pack function {i,j}.
- Sub-module mcm_dim_rf is the (N+1)×PW dimension register file. It has one write port and three combinational read ports: i-1, k, j.
- The scheduler FSM and the L/i/j/k counters live in mcm_scheduler.

## Test plan
- n=3, p={10,30,5,60}, start → writes m[1][2]=1500/s=1, m[2][3]=9000/s=2, m[1][3]=4500/s=2; done in cycle 14, err=0.
- n=3, p={2,2,2,2} (tie) → m[1][3]=16, s[1][3]=1 (lowest k).
- n=1 → single INIT write {1,1}=0, done cycle 2. n=0 and n=N+1 → done+err cycle 1, no tbl_we.
- Pulse start and dim_we during ITER of an n=4 run → no restart, dimension file unchanged, results match the golden model.
- Assert rst in cycle 6 of an n=3 run → all outputs 0 next sample, state IDLE. A following clean run completes correctly.
- Random n in 2..N with random dims, checked against a software DP → every m and s entry matches, and the cycle count matches the formula.

Source files
------------

// File: rtl/mcm_pkg.sv
// rtl/mcm_pkg.sv - shared sizes, FSM states and table address packing for the MCM scheduler
package mcm_pkg;
  localparam int N  = 8;
  localparam int PW = 8;
  localparam int CW = 32;
  localparam int IW = $clog2(N + 1);

  localparam logic [IW-1:0] N_MAX = IW'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SETUP,
    S_ITER,
    S_WB,
    S_DONE
  } state_t;

  function automatic logic [2*IW-1:0] pack_addr(input logic [IW-1:0] i, input logic [IW-1:0] j);
    return {i, j};
  endfunction
endpackage

// File: rtl/mcm_if.sv
// rtl/mcm_if.sv - host, computation-unit and table-RAM signals of the MCM scheduler
interface mcm_if;
  import mcm_pkg::*;

  logic            dim_we;
  logic [IW-1:0]   dim_addr;
  logic [PW-1:0]   dim_data;
  logic            start;
  logic [IW-1:0]   n;
  logic            busy;
  logic            done;
  logic            err;
  logic            cu_clr;
  logic            cu_en;
  logic [PW-1:0]   pi;
  logic [PW-1:0]   pk;
  logic [PW-1:0]   pj;
  logic [CW-1:0]   kc;
  logic [2*IW-1:0] tbl_ra0;
  logic [2*IW-1:0] tbl_ra1;
  logic [CW-1:0]   mki;
  logic [CW-1:0]   mkj1;
  logic [CW-1:0]   cu_min;
  logic [CW-1:0]   cu_ko;
  logic            tbl_we;
  logic [2*IW-1:0] tbl_wa;
  logic [CW-1:0]   cost_wd;
  logic [CW-1:0]   split_wd;

  modport master (
    input  dim_we, dim_addr, dim_data, start, n, mki, mkj1, cu_min, cu_ko,
    output busy, done, err, cu_clr, cu_en, pi, pk, pj, kc, tbl_ra0, tbl_ra1,
           tbl_we, tbl_wa, cost_wd, split_wd
  );

  modport slave (
    output dim_we, dim_addr, dim_data, start, n, mki, mkj1, cu_min, cu_ko,
    input  busy, done, err, cu_clr, cu_en, pi, pk, pj, kc, tbl_ra0, tbl_ra1,
           tbl_we, tbl_wa, cost_wd, split_wd
  );
endinterface

// File: rtl/mcm_dim_rf.sv
// rtl/mcm_dim_rf.sv - (N+1) x PW dimension register file, one write port, three async read ports
module mcm_dim_rf
  import mcm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [PW-1:0] i_wdata,
  input  logic [IW-1:0] i_ra_im1,
  input  logic [IW-1:0] i_ra_k,
  input  logic [IW-1:0] i_ra_j,
  output logic [PW-1:0] o_rd_im1,
  output logic [PW-1:0] o_rd_k,
  output logic [PW-1:0] o_rd_j
);
  logic [PW-1:0] r_p [0:N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a <= N; a++) r_p[a] <= '0;
    end else if (i_we && (i_waddr <= N_MAX)) begin
      r_p[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range addresses (e.g. i-1 while i is still 0) read as zero.
  assign o_rd_im1 = (i_ra_im1 <= N_MAX) ? r_p[i_ra_im1] : '0;
  assign o_rd_k   = (i_ra_k   <= N_MAX) ? r_p[i_ra_k]   : '0;
  assign o_rd_j   = (i_ra_j   <= N_MAX) ? r_p[i_ra_j]   : '0;
endmodule

// File: rtl/mcm_scheduler.sv
// rtl/mcm_scheduler.sv - matrix-chain DP sequencer: walks L/i/k, drives the min unit, writes cost/split tables
module mcm_scheduler
  import mcm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  mcm_if.master bus
);
  state_t r_state, w_next;

  logic [IW-1:0]   r_n, r_l, r_i, r_j, r_k;
  logic            r_err;
  logic [PW-1:0]   r_pi, r_pk, r_pj;
  logic [CW-1:0]   r_kc;
  logic [2*IW-1:0] r_ra0, r_ra1;

  logic            w_busy, w_valid_n, w_init_last, w_k_last, w_more_i, w_more_l;
  logic [PW-1:0]   w_rd_im1, w_rd_k, w_rd_j;
  logic [2*IW-1:0] w_ra0, w_ra1;

  assign w_valid_n   = (bus.n != '0) && (bus.n <= N_MAX);
  assign w_init_last = (r_i == r_n);
  assign w_k_last    = (r_k == r_j - IW'(1));
  assign w_more_i    = (r_i < r_n - r_l + IW'(1));
  assign w_more_l    = (r_l < r_n);
  // An invalid n passes through DONE without ever raising busy.
  assign w_busy      = (r_state != S_IDLE) && !((r_state == S_DONE) && r_err);
  assign w_ra0       = pack_addr(r_i, r_k);
  assign w_ra1       = pack_addr(r_k + IW'(1), r_j);

  mcm_dim_rf u_dim_rf (
    .clk      (clk),
    .rst      (rst),
    .i_we     (bus.dim_we && !w_busy),
    .i_waddr  (bus.dim_addr),
    .i_wdata  (bus.dim_data),
    .i_ra_im1 (r_i - IW'(1)),
    .i_ra_k   (r_k),
    .i_ra_j   (r_j),
    .o_rd_im1 (w_rd_im1),
    .o_rd_k   (w_rd_k),
    .o_rd_j   (w_rd_j)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = w_valid_n ? S_INIT : S_DONE;
      S_INIT:  if (w_init_last) w_next = (r_n == IW'(1)) ? S_DONE : S_SETUP;
      S_SETUP: w_next = S_ITER;
      S_ITER:  if (w_k_last) w_next = S_WB;
      S_WB:    w_next = (w_more_i || w_more_l) ? S_SETUP : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n   <= '0;
      r_l   <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_err <= 1'b0;
      r_pi  <= '0;
      r_pk  <= '0;
      r_pj  <= '0;
      r_kc  <= '0;
      r_ra0 <= '0;
      r_ra1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_n   <= bus.n;
          r_i   <= IW'(1);
          r_err <= !w_valid_n;
        end
        S_INIT: if (w_init_last) begin
          r_i <= IW'(1);
          r_l <= IW'(2);
        end else begin
          r_i <= r_i + IW'(1);
        end
        S_SETUP: begin
          r_j <= r_i + r_l - IW'(1);
          r_k <= r_i;
        end
        S_ITER: begin
          r_k   <= r_k + IW'(1);
          r_pi  <= w_rd_im1;
          r_pk  <= w_rd_k;
          r_pj  <= w_rd_j;
          r_kc  <= CW'(r_k);
          r_ra0 <= w_ra0;
          r_ra1 <= w_ra1;
        end
        S_WB: if (w_more_i) begin
          r_i <= r_i + IW'(1);
        end else if (w_more_l) begin
          r_l <= r_l + IW'(1);
          r_i <= IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Operands are live during ITER and frozen at their last ITER values otherwise.
  always_comb begin
    bus.busy     = w_busy;
    bus.done     = (r_state == S_DONE);
    bus.err      = (r_state == S_DONE) && r_err;
    bus.cu_clr   = (r_state == S_SETUP);
    bus.cu_en    = (r_state == S_ITER);
    bus.pi       = r_pi;
    bus.pk       = r_pk;
    bus.pj       = r_pj;
    bus.kc       = r_kc;
    bus.tbl_ra0  = r_ra0;
    bus.tbl_ra1  = r_ra1;
    bus.tbl_we   = 1'b0;
    bus.tbl_wa   = '0;
    bus.cost_wd  = '0;
    bus.split_wd = '0;
    case (r_state)
      S_INIT: begin
        bus.tbl_we = 1'b1;
        bus.tbl_wa = pack_addr(r_i, r_i);
      end
      S_ITER: begin
        bus.pi      = w_rd_im1;
        bus.pk      = w_rd_k;
        bus.pj      = w_rd_j;
        bus.kc      = CW'(r_k);
        bus.tbl_ra0 = w_ra0;
        bus.tbl_ra1 = w_ra1;
      end
      S_WB: begin
        bus.tbl_we   = 1'b1;
        bus.tbl_wa   = pack_addr(r_i, r_j);
        bus.cost_wd  = bus.cu_min;
        bus.split_wd = bus.cu_ko;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mcm_scheduler.sv
// tb/tb_mcm_scheduler.sv - self-checking bench: min-unit and table RAM models, software DP reference
module tb_mcm_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;

  mcm_if bus ();

  mcm_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] cost_ram  [0:255];
  logic [31:0] split_ram [0:255];
  int          wr_cnt;
  logic        tb_clr = 1'b0;
  logic [31:0] r_cu_min, r_cu_ko;
  logic [31:0] cu_val;

  logic [7:0]  p_ref [0:8];
  logic [31:0] m_ref [0:8][0:8];
  logic [31:0] s_ref [0:8][0:8];

  assign bus.mki    = cost_ram[bus.tbl_ra0];
  assign bus.mkj1   = cost_ram[bus.tbl_ra1];
  assign bus.cu_min = r_cu_min;
  assign bus.cu_ko  = r_cu_ko;
  assign cu_val     = bus.mki + bus.mkj1 + 32'(bus.pi) * 32'(bus.pk) * 32'(bus.pj);

  always @(posedge clk) begin
    if (tb_clr) begin
      wr_cnt <= 0;
      for (int a = 0; a < 256; a++) begin
        cost_ram[a]  <= 32'hDEAD_BEEF;
        split_ram[a] <= 32'hDEAD_BEEF;
      end
    end else if (bus.tbl_we) begin
      cost_ram[bus.tbl_wa]  <= bus.cost_wd;
      split_ram[bus.tbl_wa] <= bus.split_wd;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (bus.cu_clr) begin
      r_cu_min <= 32'hFFFF_FFFF;
      r_cu_ko  <= 32'd0;
    end else if (bus.cu_en && (cu_val < r_cu_min)) begin
      r_cu_min <= cu_val;
      r_cu_ko  <= bus.kc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_cycles(input int nn);
    int r;
    if (nn < 1 || nn > 8) return 1;
    r = 1 + nn;
    for (int l = 2; l <= nn; l++) r += (nn - l + 1) * (l + 1);
    return r;
  endfunction

  task automatic ref_dp(input int nn);
    logic [31:0] c, best, bk;
    for (int i = 1; i <= nn; i++) begin
      m_ref[i][i] = 0;
      s_ref[i][i] = 0;
    end
    for (int l = 2; l <= nn; l++) begin
      for (int i = 1; i <= nn - l + 1; i++) begin
        int j;
        j = i + l - 1;
        best = 32'hFFFF_FFFF;
        bk = 0;
        for (int k = i; k < j; k++) begin
          c = m_ref[i][k] + m_ref[k+1][j] + 32'(p_ref[i-1]) * 32'(p_ref[k]) * 32'(p_ref[j]);
          if (c < best) begin
            best = c;
            bk = 32'(k);
          end
        end
        m_ref[i][j] = best;
        s_ref[i][j] = bk;
      end
    end
  endtask

  task automatic load_dims(input int nn);
    for (int a = 0; a <= nn; a++) begin
      @(negedge clk);
      bus.dim_we = 1'b1;
      bus.dim_addr = 4'(a);
      bus.dim_data = p_ref[a];
    end
    @(negedge clk);
    bus.dim_we = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctl"}, {bus.busy, bus.done, bus.err, bus.cu_clr, bus.cu_en, bus.tbl_we}, 0);
    check_eq({tag, "_ops"}, {bus.pi, bus.pk, bus.pj, bus.kc}, 0);
    check_eq({tag, "_addr"}, {bus.tbl_ra0, bus.tbl_ra1, bus.tbl_wa}, 0);
    check_eq({tag, "_wd"}, {bus.cost_wd, bus.split_wd}, 0);
  endtask

  task automatic run_case(input int nn, input bit disturb, input string tag);
    int cyc;
    bit hit;
    bit valid;
    valid = (nn >= 1 && nn <= 8);
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
    bus.n = 4'(nn);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    hit = 0;
    check_eq({tag, "_busy1"}, bus.busy, valid);
    while (!bus.done && cyc < 3000) begin
      if (disturb && !hit && bus.cu_en) begin
        hit = 1;
        bus.start = 1'b1;
        bus.dim_we = 1'b1;
        bus.dim_addr = 4'd2;
        bus.dim_data = ~p_ref[2];
        @(negedge clk);
        bus.start = 1'b0;
        bus.dim_we = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check_eq({tag, "_cycles"}, cyc, exp_cycles(nn));
    check_eq({tag, "_err"}, bus.err, !valid);
    check_eq({tag, "_busy_done"}, bus.busy, valid);
    if (disturb) check_eq({tag, "_iter_seen"}, hit, 1);
    @(negedge clk);
    check_eq({tag, "_after"}, {bus.done, bus.busy}, 0);
    if (valid) begin
      ref_dp(nn);
      check_eq({tag, "_writes"}, wr_cnt, nn + nn * (nn - 1) / 2);
      for (int i = 1; i <= nn; i++) begin
        for (int j = i; j <= nn; j++) begin
          check_eq($sformatf("%s_m%0d%0d", tag, i, j), cost_ram[i*16+j], m_ref[i][j]);
          check_eq($sformatf("%s_s%0d%0d", tag, i, j), split_ram[i*16+j], s_ref[i][j]);
        end
      end
    end else begin
      check_eq({tag, "_writes"}, wr_cnt, 0);
    end
  endtask

  initial begin
    bus.dim_we = 1'b0;
    bus.dim_addr = '0;
    bus.dim_data = '0;
    bus.start = 1'b0;
    bus.n = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    p_ref[0] = 10; p_ref[1] = 30; p_ref[2] = 5; p_ref[3] = 60;
    load_dims(3);
    run_case(3, 0, "chain3");
    check_eq("chain3_m13_lit", cost_ram[8'h13], 4500);
    check_eq("chain3_s13_lit", split_ram[8'h13], 2);

    for (int a = 0; a <= 3; a++) p_ref[a] = 2;
    load_dims(3);
    run_case(3, 0, "tie");
    check_eq("tie_m13_lit", cost_ram[8'h13], 16);
    check_eq("tie_s13_lit", split_ram[8'h13], 1);

    run_case(1, 0, "n1");
    run_case(0, 0, "n0");
    run_case(9, 0, "n9");

    p_ref[0] = 7; p_ref[1] = 3; p_ref[2] = 11; p_ref[3] = 4; p_ref[4] = 9;
    load_dims(4);
    run_case(4, 1, "disturb");

    p_ref[0] = 10; p_ref[1] = 30; p_ref[2] = 5; p_ref[3] = 60;
    load_dims(3);
    bus.n = 4'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    load_dims(3);
    run_case(3, 0, "postrst");

    for (int r = 0; r < 6; r++) begin
      int nn;
      nn = int'($urandom_range(2, 8));
      for (int a = 0; a <= nn; a++) p_ref[a] = 8'($urandom_range(1, 255));
      load_dims(nn);
      run_case(nn, 0, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
